// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core (D/E, E/M, M/W).
// Define PIPE_STAGE_PERF_EN to add the stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W = 96,
  parameter int unsigned TNEW_W    = 2,
  parameter int unsigned TNEW_DEC  = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 clr,
  input  logic                 interrupt,
  input  logic                 valid_in,
  input  logic [31:0]          ir_in,
  input  logic [31:0]          pc_in,
  input  logic                 bd_in,
  input  logic [4:0]           wa_in,
  input  logic [TNEW_W-1:0]    tnew_in,
  input  logic [4:0]           exc_in,
  input  logic [4:0]           exc_local,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid_out,
  output logic [31:0]          ir_out,
  output logic [31:0]          pc_out,
  output logic [31:0]          pc8_out,
  output logic                 bd_out,
  output logic [4:0]           wa_out,
  output logic [TNEW_W-1:0]    tnew_out,
  output logic [4:0]           exc_out,
  output logic [PAYLOAD_W-1:0] payload_out
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  logic                 r_valid;
  logic [31:0]          r_ir;
  logic [31:0]          r_pc;
  logic [31:0]          r_pc8;
  logic                 r_bd;
  logic [4:0]           r_wa;
  logic [TNEW_W-1:0]    r_tnew;
  logic [4:0]           r_exc;
  logic [PAYLOAD_W-1:0] r_payload;

  logic                 w_bubble;
  logic                 w_load;
  logic [4:0]           w_exc_mrg;
  logic [TNEW_W-1:0]    w_tnew_ld;
  logic [31:0]          w_pc8;

  assign w_bubble  = clr | ~valid_in;
  assign w_load    = reset & ~interrupt & ~stall;
  assign w_exc_mrg = (exc_in != 5'd0) ? exc_in : exc_local;
  assign w_pc8     = pc_in + 32'd8;

  // Tnew counts down one stage per load and never wraps below zero
  if (TNEW_DEC != 0) begin : g_tnew_dec
    assign w_tnew_ld = (tnew_in == '0) ? '0
                     : tnew_in - TNEW_W'(1);
  end else begin : g_tnew_pass
    assign w_tnew_ld = tnew_in;
  end

  always_ff @(posedge clk) begin
    if (!reset || interrupt) begin
      r_valid   <= 1'b0;
      r_ir      <= '0;
      r_pc      <= '0;
      r_pc8     <= '0;
      r_bd      <= 1'b0;
      r_wa      <= '0;
      r_tnew    <= '0;
      r_exc     <= '0;
      r_payload <= '0;
    end else if (!stall) begin
      // bubbles keep PC/BD so EPC is right if an interrupt hits them
      r_pc  <= pc_in;
      r_pc8 <= w_pc8;
      r_bd  <= bd_in;
      if (w_bubble) begin
        r_valid   <= 1'b0;
        r_ir      <= '0;
        r_wa      <= '0;
        r_tnew    <= '0;
        r_exc     <= '0;
        r_payload <= '0;
      end else begin
        r_valid   <= 1'b1;
        r_ir      <= ir_in;
        r_wa      <= wa_in;
        r_tnew    <= w_tnew_ld;
        r_exc     <= w_exc_mrg;
        r_payload <= payload_in;
      end
    end
  end

  assign valid_out   = r_valid;
  assign ir_out      = r_ir;
  assign pc_out      = r_pc;
  assign pc8_out     = r_pc8;
  assign bd_out      = r_bd;
  assign wa_out      = r_wa;
  assign tnew_out    = r_tnew;
  assign exc_out     = r_exc;
  assign payload_out = r_payload;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_stall_ev;
  logic             w_bubble_ev;

  assign w_stall_ev  = reset & ~interrupt & stall;
  assign w_bubble_ev = w_load & w_bubble;

  // saturating counters; only reset clears them, interrupt does not
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_ev && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_bubble_ev && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  if (CNT_W > 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised self-checking bench for pipe_stage_reg.
// Two instances share stimulus: TNEW_DEC=1 and TNEW_DEC=0.
module tb_pipe_stage_reg;

  localparam int PW = 96;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          clr;
  logic          interrupt;
  logic          valid_in;
  logic [31:0]   ir_in;
  logic [31:0]   pc_in;
  logic          bd_in;
  logic [4:0]    wa_in;
  logic [1:0]    tnew_in;
  logic [4:0]    exc_in;
  logic [4:0]    exc_local;
  logic [PW-1:0] payload_in;

  logic          valid_out, valid_o0;
  logic [31:0]   ir_out, ir_o0;
  logic [31:0]   pc_out, pc_o0;
  logic [31:0]   pc8_out, pc8_o0;
  logic          bd_out, bd_o0;
  logic [4:0]    wa_out, wa_o0;
  logic [1:0]    tnew_out, tnew_o0;
  logic [4:0]    exc_out, exc_o0;
  logic [PW-1:0] payload_out, payload_o0;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]    stall_cnt, stall_cnt0;
  logic [3:0]    bubble_cnt, bubble_cnt0;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .PAYLOAD_W(PW), .TNEW_W(2), .TNEW_DEC(1), .CNT_W(4)
  ) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .clr(clr),
    .interrupt(interrupt), .valid_in(valid_in),
    .ir_in(ir_in), .pc_in(pc_in), .bd_in(bd_in),
    .wa_in(wa_in), .tnew_in(tnew_in), .exc_in(exc_in),
    .exc_local(exc_local), .payload_in(payload_in),
    .valid_out(valid_out), .ir_out(ir_out), .pc_out(pc_out),
    .pc8_out(pc8_out), .bd_out(bd_out), .wa_out(wa_out),
    .tnew_out(tnew_out), .exc_out(exc_out),
    .payload_out(payload_out)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_reg #(
    .PAYLOAD_W(PW), .TNEW_W(2), .TNEW_DEC(0), .CNT_W(4)
  ) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .clr(clr),
    .interrupt(interrupt), .valid_in(valid_in),
    .ir_in(ir_in), .pc_in(pc_in), .bd_in(bd_in),
    .wa_in(wa_in), .tnew_in(tnew_in), .exc_in(exc_in),
    .exc_local(exc_local), .payload_in(payload_in),
    .valid_out(valid_o0), .ir_out(ir_o0), .pc_out(pc_o0),
    .pc8_out(pc8_o0), .bd_out(bd_o0), .wa_out(wa_o0),
    .tnew_out(tnew_o0), .exc_out(exc_o0),
    .payload_out(payload_o0)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // reference stage contents
  bit       m_valid;
  bit [31:0] m_ir, m_pc, m_pc8;
  bit       m_bd;
  bit [4:0] m_wa, m_exc;
  int       m_tnew1, m_tnew0;
  bit [PW-1:0] m_pay;
  int       m_scnt, m_bcnt;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void clear_model();
    m_valid = 0; m_ir = 0; m_pc = 0; m_pc8 = 0; m_bd = 0;
    m_wa = 0; m_exc = 0; m_tnew1 = 0; m_tnew0 = 0; m_pay = 0;
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      clear_model();
      m_scnt = 0;
      m_bcnt = 0;
    end else if (interrupt) begin
      clear_model();
    end else if (stall) begin
      m_scnt = (m_scnt < 15) ? m_scnt + 1 : 15;
    end else begin
      m_pc  = pc_in;
      m_pc8 = pc_in + 32'd8;
      m_bd  = bd_in;
      if (clr || !valid_in) begin
        m_valid = 0; m_ir = 0; m_wa = 0; m_exc = 0;
        m_tnew1 = 0; m_tnew0 = 0; m_pay = 0;
        m_bcnt = (m_bcnt < 15) ? m_bcnt + 1 : 15;
      end else begin
        m_valid = 1; m_ir = ir_in; m_wa = wa_in;
        m_pay = payload_in;
        m_exc = (exc_in != 0) ? exc_in : exc_local;
        m_tnew0 = int'(tnew_in);
        m_tnew1 = (tnew_in == 0) ? 0 : int'(tnew_in) - 1;
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("valid", 128'(valid_out), 128'(m_valid));
    chk("ir", 128'(ir_out), 128'(m_ir));
    chk("pc", 128'(pc_out), 128'(m_pc));
    chk("pc8", 128'(pc8_out), 128'(m_pc8));
    chk("bd", 128'(bd_out), 128'(m_bd));
    chk("wa", 128'(wa_out), 128'(m_wa));
    chk("tnew_dec", 128'(tnew_out), 128'(m_tnew1));
    chk("exc", 128'(exc_out), 128'(m_exc));
    chk("payload", 128'(payload_out), 128'(m_pay));
    chk("tnew_pass", 128'(tnew_o0), 128'(m_tnew0));
    chk("ir_d0", 128'(ir_o0), 128'(m_ir));
    chk("wa_d0", 128'(wa_o0), 128'(m_wa));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 128'(stall_cnt), 128'(m_scnt));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bcnt));
`endif
  endtask

  task automatic idle_ctl();
    reset = 1; stall = 0; clr = 0; interrupt = 0;
  endtask

  task automatic set_ins(input logic [31:0] ir, input logic [31:0] pc,
                         input logic bd, input logic [4:0] wa,
                         input logic [1:0] tn, input logic [4:0] ei,
                         input logic [4:0] el);
    valid_in = 1; ir_in = ir; pc_in = pc; bd_in = bd; wa_in = wa;
    tnew_in = tn; exc_in = ei; exc_local = el;
    payload_in = {$urandom, $urandom, $urandom};
  endtask

  task automatic rand_ins();
    valid_in   = ($urandom_range(0, 7) != 0);
    ir_in      = $urandom;
    pc_in      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
    bd_in      = 1'($urandom);
    wa_in      = 5'($urandom);
    tnew_in    = 2'($urandom);
    exc_in     = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
    exc_local  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
    payload_in = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    clear_model();
    m_scnt = 0;
    m_bcnt = 0;

    // 1: reset with every input nonzero, then first load
    reset = 0; stall = 1; clr = 1; interrupt = 1;
    set_ins(32'hFFFF_FFFF, 32'h1234_5678, 1, 5'd31, 2'd3, 5'd7, 5'd9);
    repeat (2) tick();
    chk("rst_valid", 128'(valid_out), 128'd0);
    idle_ctl();
    set_ins(32'h8C08_0004, 32'h0000_3000, 0, 5'd8, 2'd2, 5'd0, 5'd0);
    tick();
    chk("t1_ir", 128'(ir_out), 128'h8C08_0004);
    chk("t1_pc8", 128'(pc8_out), 128'h0000_3008);
    chk("t1_tnew", 128'(tnew_out), 128'd1);
    chk("t1_valid", 128'(valid_out), 128'd1);

    // 2: tnew saturation and pass-through
    set_ins(32'h0000_0020, 32'h0000_3004, 0, 5'd2, 2'd0, 5'd0, 5'd0);
    tick();
    chk("t2_sat", 128'(tnew_out), 128'd0);
    set_ins(32'h0000_0024, 32'h0000_3008, 0, 5'd3, 2'd3, 5'd0, 5'd0);
    tick();
    chk("t2_pass", 128'(tnew_o0), 128'd3);
    chk("t2_dec", 128'(tnew_out), 128'd2);

    // 3: stall with clr holds instruction A
    set_ins(32'hAAAA_0001, 32'h0000_3100, 1, 5'd9, 2'd2, 5'd0, 5'd6);
    tick();
    stall = 1; clr = 1;
    for (int i = 0; i < 3; i++) begin
      rand_ins();
      tick();
      chk("t3_hold_ir", 128'(ir_out), 128'hAAAA_0001);
      chk("t3_hold_tnew", 128'(tnew_out), 128'd1);
    end
    stall = 0; clr = 0;
    set_ins(32'hBBBB_0002, 32'h0000_3104, 0, 5'd10, 2'd1, 5'd0, 5'd0);
    tick();
    chk("t3_next", 128'(ir_out), 128'hBBBB_0002);

    // 4: bubble keeps PC/BD only
    set_ins(32'hCCCC_0003, 32'h0000_3010, 1, 5'd5, 2'd2, 5'd4, 5'd0);
    clr = 1;
    tick();
    chk("t4_valid", 128'(valid_out), 128'd0);
    chk("t4_wa", 128'(wa_out), 128'd0);
    chk("t4_exc", 128'(exc_out), 128'd0);
    chk("t4_pc", 128'(pc_out), 128'h0000_3010);
    chk("t4_bd", 128'(bd_out), 128'd1);
    clr = 0;

    // 5: exception merge and interrupt during stall
    set_ins(32'h1, 32'h0000_3200, 0, 5'd1, 2'd1, 5'd0, 5'd10);
    tick();
    chk("t5_local", 128'(exc_out), 128'd10);
    set_ins(32'h2, 32'h0000_3204, 0, 5'd1, 2'd1, 5'd4, 5'd10);
    tick();
    chk("t5_older", 128'(exc_out), 128'd4);
    stall = 1; interrupt = 1;
    tick();
    chk("t5_int_pc", 128'(pc_out), 128'd0);
    chk("t5_int_valid", 128'(valid_out), 128'd0);
    idle_ctl();

`ifdef PIPE_STAGE_PERF_EN
    // 6: counters saturate, survive interrupt, clear on reset
    reset = 0;
    tick();
    idle_ctl();
    stall = 1;
    repeat (20) tick();
    chk("t6_scnt", 128'(stall_cnt), 128'd15);
    stall = 0; clr = 1;
    repeat (3) tick();
    chk("t6_bcnt", 128'(bubble_cnt), 128'd3);
    clr = 0; interrupt = 1;
    tick();
    chk("t6_int_bcnt", 128'(bubble_cnt), 128'd3);
    interrupt = 0; reset = 0;
    tick();
    chk("t6_rst_scnt", 128'(stall_cnt), 128'd0);
    idle_ctl();
`endif

    // reset released while stalled keeps zeros until a load
    reset = 0;
    rand_ins();
    tick();
    reset = 1; stall = 1;
    repeat (2) tick();
    chk("rst_stall_ir", 128'(ir_out), 128'd0);
    stall = 0;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 49) != 0);
      interrupt = ($urandom_range(0, 29) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      clr       = ($urandom_range(0, 5) == 0);
      rand_ins();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
